// File: rtl/axi_narrow_to_wide_burst.sv
// AXI width upsizer: narrow upstream master to wide downstream slave.
// Address channels pass through; W/R beats are steered by per-channel burst replay.
module axi_narrow_to_wide_burst #(
  parameter int SOURCE_WIDTH = 32,
  parameter int TARGET_WIDTH = 128,
  parameter int CMD_DEPTH    = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  // upstream write address
  input  logic [31:0]                   u_axi_awaddr,
  input  logic [2:0]                    u_axi_awsize,
  input  logic [7:0]                    u_axi_awlen,
  input  logic [1:0]                    u_axi_awburst,
  input  logic                          u_axi_awvalid,
  output logic                          u_axi_awready,
  // upstream write data
  input  logic [SOURCE_WIDTH-1:0]       u_axi_wdata,
  input  logic [SOURCE_WIDTH/8-1:0]     u_axi_wstrb,
  input  logic                          u_axi_wlast,
  input  logic                          u_axi_wvalid,
  output logic                          u_axi_wready,
  // upstream write response
  output logic [1:0]                    u_axi_bresp,
  output logic                          u_axi_bvalid,
  input  logic                          u_axi_bready,
  // upstream read address
  input  logic [31:0]                   u_axi_araddr,
  input  logic [2:0]                    u_axi_arsize,
  input  logic [7:0]                    u_axi_arlen,
  input  logic [1:0]                    u_axi_arburst,
  input  logic                          u_axi_arvalid,
  output logic                          u_axi_arready,
  // upstream read data
  output logic [SOURCE_WIDTH-1:0]       u_axi_rdata,
  output logic [1:0]                    u_axi_rresp,
  output logic                          u_axi_rlast,
  output logic                          u_axi_rvalid,
  input  logic                          u_axi_rready,
  // downstream write address
  output logic [31:0]                   d_axi_awaddr,
  output logic [2:0]                    d_axi_awsize,
  output logic [7:0]                    d_axi_awlen,
  output logic [1:0]                    d_axi_awburst,
  output logic                          d_axi_awvalid,
  input  logic                          d_axi_awready,
  // downstream write data
  output logic [TARGET_WIDTH-1:0]       d_axi_wdata,
  output logic [TARGET_WIDTH/8-1:0]     d_axi_wstrb,
  output logic                          d_axi_wlast,
  output logic                          d_axi_wvalid,
  input  logic                          d_axi_wready,
  // downstream write response
  input  logic [1:0]                    d_axi_bresp,
  input  logic                          d_axi_bvalid,
  output logic                          d_axi_bready,
  // downstream read address
  output logic [31:0]                   d_axi_araddr,
  output logic [2:0]                    d_axi_arsize,
  output logic [7:0]                    d_axi_arlen,
  output logic [1:0]                    d_axi_arburst,
  output logic                          d_axi_arvalid,
  input  logic                          d_axi_arready,
  // downstream read data
  input  logic [TARGET_WIDTH-1:0]       d_axi_rdata,
  input  logic [1:0]                    d_axi_rresp,
  input  logic                          d_axi_rlast,
  input  logic                          d_axi_rvalid,
  output logic                          d_axi_rready,
  // sticky error flags
  output logic                          err_wlast,
  output logic                          err_size
);

  localparam int SB = SOURCE_WIDTH / 8;
  localparam int SA = $clog2(SB);
  localparam int TA = $clog2(TARGET_WIDTH / 8);
  localparam int LW = TA - SA;
  localparam int NL = TARGET_WIDTH / SOURCE_WIDTH;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CH_W = 0;
  localparam int CH_R = 1;
  localparam logic [2:0] SA3 = 3'(SA);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [TA-1:0] addr;
    logic [2:0]    size;
    logic [7:0]    len;
    logic [1:0]    burst;
  } cmd_t;

  // Index 0 is the write channel, index 1 the read channel.
  cmd_t            r_mem   [2][CMD_DEPTH];
  logic [PW-1:0]   r_wptr  [2];
  logic [PW-1:0]   r_rptr  [2];
  logic [PW:0]     r_count [2];
  logic [1:0]      r_state [2];
  cmd_t            r_cmd   [2];
  logic [7:0]      r_beat  [2];
  logic            r_err_wlast;
  logic            r_err_size;

  cmd_t            w_in    [2];
  cmd_t            w_head  [2];
  logic [LW-1:0]   w_lane  [2];
  logic [1:0]      w_push, w_pop, w_beat, w_last_beat, w_active, w_full, w_empty;
  logic            w_aw_open, w_ar_open;

  function automatic cmd_t clamp_size(input cmd_t c);
    clamp_size = c;
    if (c.size > SA3) clamp_size.size = SA3;
  endfunction

  // Only the low TA address bits select a lane, so carries above them are dropped.
  function automatic logic [TA-1:0] next_addr(input cmd_t c);
    logic [TA-1:0] step;
    logic [TA-1:0] mask;
    step = TA'(32'd1 << c.size);
    mask = TA'(((32'(c.len) + 32'd1) << c.size) - 32'd1);
    case (c.burst)
      BURST_FIXED: next_addr = c.addr;
      BURST_WRAP:  next_addr = (c.addr & ~mask) | ((c.addr + step) & mask);
      default:     next_addr = (c.addr & ~(step - TA'(1))) + step;
    endcase
  endfunction

  // Address channels: pass-through, gated only by command FIFO space.
  assign w_aw_open     = ~areset & ~w_full[CH_W];
  assign w_ar_open     = ~areset & ~w_full[CH_R];
  assign d_axi_awaddr  = u_axi_awaddr;
  assign d_axi_awsize  = u_axi_awsize;
  assign d_axi_awlen   = u_axi_awlen;
  assign d_axi_awburst = u_axi_awburst;
  assign d_axi_awvalid = u_axi_awvalid & w_aw_open;
  assign u_axi_awready = d_axi_awready & w_aw_open;
  assign d_axi_araddr  = u_axi_araddr;
  assign d_axi_arsize  = u_axi_arsize;
  assign d_axi_arlen   = u_axi_arlen;
  assign d_axi_arburst = u_axi_arburst;
  assign d_axi_arvalid = u_axi_arvalid & w_ar_open;
  assign u_axi_arready = d_axi_arready & w_ar_open;

  assign u_axi_bresp  = d_axi_bresp;
  assign u_axi_bvalid = d_axi_bvalid;
  assign d_axi_bready = u_axi_bready;

  assign w_in[CH_W] = {u_axi_awaddr[TA-1:0], u_axi_awsize, u_axi_awlen, u_axi_awburst};
  assign w_in[CH_R] = {u_axi_araddr[TA-1:0], u_axi_arsize, u_axi_arlen, u_axi_arburst};
  assign w_push[CH_W] = u_axi_awvalid & u_axi_awready;
  assign w_push[CH_R] = u_axi_arvalid & u_axi_arready;
  assign w_beat[CH_W] = u_axi_wvalid & d_axi_wready & w_active[CH_W];
  assign w_beat[CH_R] = d_axi_rvalid & u_axi_rready & w_active[CH_R];

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      w_head[ch]      = r_mem[ch][r_rptr[ch]];
      w_full[ch]      = (r_count[ch] == (PW+1)'(CMD_DEPTH));
      w_empty[ch]     = (r_count[ch] == '0);
      w_active[ch]    = (r_state[ch] == ST_ACTIVE);
      w_last_beat[ch] = (r_beat[ch] == r_cmd[ch].len);
      w_lane[ch]      = r_cmd[ch].addr[TA-1:SA];
      // The FIFO slot is held until the burst's last beat, so the tracked burst counts as occupancy.
      w_pop[ch]       = w_beat[ch] & w_last_beat[ch];
    end
  end

  // NOTE: command storage has no reset; the count and pointers alone decide what is valid.
  always_ff @(posedge aclk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (w_push[ch]) r_mem[ch][r_wptr[ch]] <= w_in[ch];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int ch = 0; ch < 2; ch++) begin
        r_wptr[ch]  <= '0;
        r_rptr[ch]  <= '0;
        r_count[ch] <= '0;
        r_state[ch] <= ST_IDLE;
        r_cmd[ch]   <= '0;
        r_beat[ch]  <= '0;
      end
      r_err_wlast <= 1'b0;
      r_err_size  <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (w_push[ch]) r_wptr[ch] <= r_wptr[ch] + PW'(1);
        if (w_pop[ch])  r_rptr[ch] <= r_rptr[ch] + PW'(1);
        if (w_push[ch] && !w_pop[ch])      r_count[ch] <= r_count[ch] + (PW+1)'(1);
        else if (!w_push[ch] && w_pop[ch]) r_count[ch] <= r_count[ch] - (PW+1)'(1);

        case (r_state[ch])
          ST_IDLE: begin
            if (!w_empty[ch]) begin
              r_cmd[ch]   <= clamp_size(w_head[ch]);
              r_beat[ch]  <= '0;
              r_state[ch] <= ST_LOAD;
            end
          end
          ST_LOAD: r_state[ch] <= ST_ACTIVE;
          ST_ACTIVE: begin
            if (w_beat[ch]) begin
              r_beat[ch]     <= r_beat[ch] + 8'd1;
              r_cmd[ch].addr <= next_addr(r_cmd[ch]);
              if (w_last_beat[ch]) r_state[ch] <= ST_IDLE;
            end
          end
          default: r_state[ch] <= ST_IDLE;
        endcase
      end

      if ((w_push[CH_W] && (u_axi_awsize > SA3)) || (w_push[CH_R] && (u_axi_arsize > SA3)))
        r_err_size <= 1'b1;
      if (w_beat[CH_W] && (u_axi_wlast != w_last_beat[CH_W]))
        r_err_wlast <= 1'b1;
    end
  end

  assign err_wlast = r_err_wlast;
  assign err_size  = r_err_size;

  assign d_axi_wvalid = u_axi_wvalid & w_active[CH_W];
  assign u_axi_wready = d_axi_wready & w_active[CH_W];
  assign d_axi_wlast  = u_axi_wlast;
  assign u_axi_rvalid = d_axi_rvalid & w_active[CH_R];
  assign d_axi_rready = u_axi_rready & w_active[CH_R];
  assign u_axi_rresp  = d_axi_rresp;
  assign u_axi_rlast  = d_axi_rlast;

  // NOTE: every output driven here gets a default first so no latch is inferred.
  always_comb begin
    d_axi_wdata = '0;
    d_axi_wstrb = '0;
    u_axi_rdata = '0;
    for (int l = 0; l < NL; l++) begin
      if (w_lane[CH_W] == LW'(l)) begin
        d_axi_wdata[l*SOURCE_WIDTH +: SOURCE_WIDTH] = u_axi_wdata;
        d_axi_wstrb[l*SB +: SB]                     = u_axi_wstrb;
      end
      if (w_lane[CH_R] == LW'(l))
        u_axi_rdata = d_axi_rdata[l*SOURCE_WIDTH +: SOURCE_WIDTH];
    end
  end

endmodule

// File: tb/tb_axi_narrow_to_wide_burst.sv
// Directed bench for axi_narrow_to_wide_burst (32-bit upstream, 128-bit downstream, 2-deep FIFOs).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_axi_narrow_to_wide_burst;

  localparam int SW = 32;
  localparam int TW = 128;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [31:0]     u_axi_awaddr = '0, u_axi_araddr = '0;
  logic [2:0]      u_axi_awsize = '0, u_axi_arsize = '0;
  logic [7:0]      u_axi_awlen = '0, u_axi_arlen = '0;
  logic [1:0]      u_axi_awburst = '0, u_axi_arburst = '0;
  logic            u_axi_awvalid = 1'b0, u_axi_awready, u_axi_arvalid = 1'b0, u_axi_arready;
  logic [SW-1:0]   u_axi_wdata = '0, u_axi_rdata;
  logic [SW/8-1:0] u_axi_wstrb = '0;
  logic            u_axi_wlast = 1'b0, u_axi_wvalid = 1'b0, u_axi_wready;
  logic [1:0]      u_axi_bresp, u_axi_rresp;
  logic            u_axi_bvalid, u_axi_bready = 1'b0;
  logic            u_axi_rlast, u_axi_rvalid, u_axi_rready = 1'b0;
  logic [31:0]     d_axi_awaddr, d_axi_araddr;
  logic [2:0]      d_axi_awsize, d_axi_arsize;
  logic [7:0]      d_axi_awlen, d_axi_arlen;
  logic [1:0]      d_axi_awburst, d_axi_arburst;
  logic            d_axi_awvalid, d_axi_awready = 1'b1, d_axi_arvalid, d_axi_arready = 1'b1;
  logic [TW-1:0]   d_axi_wdata, d_axi_rdata = '0;
  logic [TW/8-1:0] d_axi_wstrb;
  logic            d_axi_wlast, d_axi_wvalid, d_axi_wready = 1'b1;
  logic [1:0]      d_axi_bresp = '0, d_axi_rresp = '0;
  logic            d_axi_bvalid = 1'b0, d_axi_bready;
  logic            d_axi_rlast = 1'b0, d_axi_rvalid = 1'b0, d_axi_rready;
  logic            err_wlast, err_size;

  axi_narrow_to_wide_burst #(.SOURCE_WIDTH(SW), .TARGET_WIDTH(TW), .CMD_DEPTH(2)) dut (
    .aclk(aclk), .areset(areset),
    .u_axi_awaddr(u_axi_awaddr), .u_axi_awsize(u_axi_awsize), .u_axi_awlen(u_axi_awlen),
    .u_axi_awburst(u_axi_awburst), .u_axi_awvalid(u_axi_awvalid), .u_axi_awready(u_axi_awready),
    .u_axi_wdata(u_axi_wdata), .u_axi_wstrb(u_axi_wstrb), .u_axi_wlast(u_axi_wlast),
    .u_axi_wvalid(u_axi_wvalid), .u_axi_wready(u_axi_wready),
    .u_axi_bresp(u_axi_bresp), .u_axi_bvalid(u_axi_bvalid), .u_axi_bready(u_axi_bready),
    .u_axi_araddr(u_axi_araddr), .u_axi_arsize(u_axi_arsize), .u_axi_arlen(u_axi_arlen),
    .u_axi_arburst(u_axi_arburst), .u_axi_arvalid(u_axi_arvalid), .u_axi_arready(u_axi_arready),
    .u_axi_rdata(u_axi_rdata), .u_axi_rresp(u_axi_rresp), .u_axi_rlast(u_axi_rlast),
    .u_axi_rvalid(u_axi_rvalid), .u_axi_rready(u_axi_rready),
    .d_axi_awaddr(d_axi_awaddr), .d_axi_awsize(d_axi_awsize), .d_axi_awlen(d_axi_awlen),
    .d_axi_awburst(d_axi_awburst), .d_axi_awvalid(d_axi_awvalid), .d_axi_awready(d_axi_awready),
    .d_axi_wdata(d_axi_wdata), .d_axi_wstrb(d_axi_wstrb), .d_axi_wlast(d_axi_wlast),
    .d_axi_wvalid(d_axi_wvalid), .d_axi_wready(d_axi_wready),
    .d_axi_bresp(d_axi_bresp), .d_axi_bvalid(d_axi_bvalid), .d_axi_bready(d_axi_bready),
    .d_axi_araddr(d_axi_araddr), .d_axi_arsize(d_axi_arsize), .d_axi_arlen(d_axi_arlen),
    .d_axi_arburst(d_axi_arburst), .d_axi_arvalid(d_axi_arvalid), .d_axi_arready(d_axi_arready),
    .d_axi_rdata(d_axi_rdata), .d_axi_rresp(d_axi_rresp), .d_axi_rlast(d_axi_rlast),
    .d_axi_rvalid(d_axi_rvalid), .d_axi_rready(d_axi_rready),
    .err_wlast(err_wlast), .err_size(err_size)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_aw(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    u_axi_awaddr = addr; u_axi_awsize = size; u_axi_awlen = len; u_axi_awburst = burst;
    u_axi_awvalid = 1'b1;
    #1;
    n = 0;
    while (!u_axi_awready && n < 50) begin @(posedge aclk); #1; n++; end
    check({tag, "_awready"}, u_axi_awready, 1'b1);
    check({tag, "_awaddr_pass"}, d_axi_awaddr, addr);
    @(posedge aclk); #1;
    u_axi_awvalid = 1'b0;
  endtask

  task automatic send_ar(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    u_axi_araddr = addr; u_axi_arsize = size; u_axi_arlen = len; u_axi_arburst = burst;
    u_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!u_axi_arready && n < 50) begin @(posedge aclk); #1; n++; end
    check({tag, "_arready"}, u_axi_arready, 1'b1);
    check({tag, "_arlen_pass"}, d_axi_arlen, len);
    @(posedge aclk); #1;
    u_axi_arvalid = 1'b0;
  endtask

  // One upstream W beat; expected lane placement is computed from the hand-derived lane index.
  task automatic w_beat(input string tag, input logic [31:0] data, input logic [3:0] strb,
                        input logic last, input int lane);
    logic [127:0] exp_d;
    logic [15:0]  exp_s;
    int n;
    exp_d = 128'(data) << (32 * lane);
    exp_s = 16'(strb) << (4 * lane);
    u_axi_wdata = data; u_axi_wstrb = strb; u_axi_wlast = last; u_axi_wvalid = 1'b1;
    #1;
    n = 0;
    while (!u_axi_wready && n < 50) begin @(posedge aclk); #1; n++; end
    check({tag, "_wready"}, u_axi_wready, 1'b1);
    check({tag, "_wdata"}, d_axi_wdata, exp_d);
    check({tag, "_wstrb"}, d_axi_wstrb, exp_s);
    check({tag, "_wlast"}, d_axi_wlast, last);
    @(posedge aclk); #1;
    u_axi_wvalid = 1'b0; u_axi_wlast = 1'b0;
  endtask

  task automatic r_beat(input string tag, input logic [127:0] rdata, input logic last,
                        input logic [31:0] exp);
    int n;
    d_axi_rdata = rdata; d_axi_rlast = last; d_axi_rvalid = 1'b1; u_axi_rready = 1'b1;
    #1;
    n = 0;
    while (!u_axi_rvalid && n < 50) begin @(posedge aclk); #1; n++; end
    check({tag, "_rvalid"}, u_axi_rvalid, 1'b1);
    check({tag, "_rdata"}, u_axi_rdata, exp);
    check({tag, "_rlast"}, u_axi_rlast, last);
    @(posedge aclk); #1;
    d_axi_rvalid = 1'b0; u_axi_rready = 1'b0;
  endtask

  task automatic check_gated(input string tag);
    check({tag, "_d_awvalid"}, d_axi_awvalid, 1'b0);
    check({tag, "_u_awready"}, u_axi_awready, 1'b0);
    check({tag, "_d_arvalid"}, d_axi_arvalid, 1'b0);
    check({tag, "_u_arready"}, u_axi_arready, 1'b0);
    check({tag, "_d_wvalid"},  d_axi_wvalid,  1'b0);
    check({tag, "_u_wready"},  u_axi_wready,  1'b0);
    check({tag, "_u_rvalid"},  u_axi_rvalid,  1'b0);
    check({tag, "_d_rready"},  d_axi_rready,  1'b0);
    check({tag, "_err_wlast"}, err_wlast,     1'b0);
    check({tag, "_err_size"},  err_size,      1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] rd;
    rd = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};

    // Reset holds every gated valid/ready low even with all requests raised.
    u_axi_awvalid = 1'b1; u_axi_arvalid = 1'b1; u_axi_wvalid = 1'b1;
    d_axi_rvalid = 1'b1; u_axi_rready = 1'b1;
    #12;
    check_gated("reset");
    u_axi_awvalid = 1'b0; u_axi_arvalid = 1'b0; u_axi_wvalid = 1'b0;
    d_axi_rvalid = 1'b0; u_axi_rready = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;

    // INCR: lanes 1,2,3,0; tracker is still loading the cycle after acceptance.
    send_aw("incr", 32'h104, 3'd2, 8'd3, INCR);
    u_axi_wvalid = 1'b1;
    #1;
    check("incr_load_bubble", u_axi_wready, 1'b0);
    u_axi_wvalid = 1'b0;
    w_beat("incr_b0", 32'hA0000000, 4'hF, 1'b0, 1);
    w_beat("incr_b1", 32'hA0000001, 4'hF, 1'b0, 2);
    w_beat("incr_b2", 32'hA0000002, 4'hF, 1'b0, 3);
    w_beat("incr_b3", 32'hA0000003, 4'hF, 1'b1, 0);

    // WRAP: 16-byte container at 0x100, lanes 2,3,0,1.
    send_aw("wrap", 32'h108, 3'd2, 8'd3, WRAP);
    w_beat("wrap_b0", 32'hB0000000, 4'hF, 1'b0, 2);
    w_beat("wrap_b1", 32'hB0000001, 4'hF, 1'b0, 3);
    w_beat("wrap_b2", 32'hB0000002, 4'hF, 1'b0, 0);
    w_beat("wrap_b3", 32'hB0000003, 4'hF, 1'b1, 1);
    check("wrap_err_wlast", err_wlast, 1'b0);

    // FIXED: every beat stays in lane 3.
    send_aw("fixed", 32'h10C, 3'd2, 8'd2, FIXED);
    w_beat("fixed_b0", 32'hC0000000, 4'hF, 1'b0, 3);
    w_beat("fixed_b1", 32'hC0000001, 4'h3, 1'b0, 3);
    w_beat("fixed_b2", 32'hC0000002, 4'hF, 1'b1, 3);

    // Read path: halfword INCR from 0 -> addresses 0,2,4 -> lanes 0,0,1.
    send_ar("rd", 32'h0, 3'd1, 8'd2, INCR);
    r_beat("rd_b0", rd, 1'b0, 32'h00000000);
    r_beat("rd_b1", rd, 1'b0, 32'h00000000);
    r_beat("rd_b2", rd, 1'b1, 32'h11111111);

    // B channel pass-through.
    d_axi_bvalid = 1'b1; d_axi_bresp = 2'b10; u_axi_bready = 1'b1;
    #1;
    check("b_valid", u_axi_bvalid, 1'b1);
    check("b_resp",  u_axi_bresp,  2'b10);
    check("b_ready", d_axi_bready, 1'b1);
    d_axi_bvalid = 1'b0; u_axi_bready = 1'b0;
    @(posedge aclk); #1;

    // Early wlast on beat 1 flags an error but the burst still runs 4 beats.
    send_aw("wl", 32'h100, 3'd2, 8'd3, INCR);
    w_beat("wl_b0", 32'hD0000000, 4'hF, 1'b0, 0);
    w_beat("wl_b1", 32'hD0000001, 4'hF, 1'b1, 1);
    check("wl_err_set", err_wlast, 1'b1);
    w_beat("wl_b2", 32'hD0000002, 4'hF, 1'b0, 2);
    w_beat("wl_b3", 32'hD0000003, 4'hF, 1'b1, 3);
    check("wl_err_sticky", err_wlast, 1'b1);
    u_axi_wvalid = 1'b1;
    #1;
    check("wl_done_wready", u_axi_wready, 1'b0);
    u_axi_wvalid = 1'b0;
    @(posedge aclk); #1;

    // Oversized AWSIZE: flagged, passed through, tracker steps by 4 bytes.
    send_aw("sz", 32'h4, 3'd3, 8'd1, INCR);
    check("sz_err", err_size, 1'b1);
    check("sz_pass", d_axi_awsize, 3'd3);
    w_beat("sz_b0", 32'hE0000000, 4'hF, 1'b0, 1);
    w_beat("sz_b1", 32'hE0000001, 4'hF, 1'b1, 2);

    // Reset mid-burst, then a fresh burst steers from its own start lane.
    send_aw("rst_pre", 32'h108, 3'd2, 8'd3, INCR);
    w_beat("rst_pre_b0", 32'hF0000000, 4'hF, 1'b0, 2);
    u_axi_awvalid = 1'b1; u_axi_arvalid = 1'b1; u_axi_wvalid = 1'b1;
    d_axi_rvalid = 1'b1; u_axi_rready = 1'b1;
    areset = 1'b1;
    #1;
    check_gated("rst_mid");
    @(posedge aclk); #1;
    u_axi_awvalid = 1'b0; u_axi_arvalid = 1'b0; u_axi_wvalid = 1'b0;
    d_axi_rvalid = 1'b0; u_axi_rready = 1'b0;
    areset = 1'b0;
    @(posedge aclk); #1;
    send_aw("fresh", 32'h8, 3'd2, 8'd1, INCR);
    w_beat("fresh_b0", 32'h12340000, 4'hF, 1'b0, 2);
    w_beat("fresh_b1", 32'h12340001, 4'hF, 1'b1, 3);

    // Back-pressure: 1st burst tracked, 2nd queued, 3rd blocked until 1st burst ends.
    send_aw("q1", 32'h00, 3'd2, 8'd1, INCR);
    send_aw("q2", 32'h20, 3'd2, 8'd0, INCR);
    u_axi_awaddr = 32'h34; u_axi_awsize = 3'd2; u_axi_awlen = 8'd0; u_axi_awburst = INCR;
    u_axi_awvalid = 1'b1;
    #1;
    check("q3_blocked_awready", u_axi_awready, 1'b0);
    check("q3_blocked_awvalid", d_axi_awvalid, 1'b0);
    repeat (3) @(posedge aclk);
    #1;
    check("q3_still_blocked", u_axi_awready, 1'b0);
    w_beat("q1_b0", 32'h51000000, 4'hF, 1'b0, 0);
    check("q3_blocked_mid", u_axi_awready, 1'b0);
    w_beat("q1_b1", 32'h51000001, 4'hF, 1'b1, 1);
    check("q3_open_awready", u_axi_awready, 1'b1);
    check("q3_open_awvalid", d_axi_awvalid, 1'b1);
    @(posedge aclk); #1;
    u_axi_awvalid = 1'b0;
    w_beat("q2_b0", 32'h52000000, 4'hF, 1'b1, 0);
    w_beat("q3_b0", 32'h53000000, 4'hF, 1'b1, 1);
    u_axi_wvalid = 1'b1;
    #1;
    check("q_drained_wready", u_axi_wready, 1'b0);
    u_axi_wvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
